// File: rtl/digit_scan_mux_pkg.sv
// Shared definitions for the multiplexed digit scanner: FSM state
// encoding and a width helper for the prescaler and tick counter.
package digit_scan_mux_pkg;

  // Scanner states: a slot is a lit SHOW phase followed by a dark GAP.
  typedef enum logic {
    S_GAP  = 1'b0,
    S_SHOW = 1'b1
  } scan_state_t;

  // Bits needed to hold values 0..value-1, never less than 1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/digit_scan_mux_prescaler.sv
// Free-running prescaler: counts 0..DIV-1 and flags the last count as
// the scan tick that advances the digit scanner.
module scan_prescaler
  import digit_scan_mux_pkg::*;
#(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Wrap to zero after the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed BCD digit scanner. Latches NUM_DIGITS digits into a
// shadow register and lights them one at a time: each slot is SHOW_TICKS
// lit scan ticks followed by GAP_TICKS dark ticks. bcd_out and n_en feed
// the 7-segment decoder; dig_sel_n drives the display common pins.
//
// update is a plain one-cycle strobe with no back-pressure: the digits
// are taken on the edge where update is high, and only become visible
// at the next SHOW entry so a lit slot never tears.
//
// The FSM state is kept in the named signal 'state' (scan_state_t) so
// checkers can bind to it directly.
module digit_scan_mux
  import digit_scan_mux_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 1000,
  parameter int SHOW_TICKS = 4,
  parameter int GAP_TICKS  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    update,
  input  logic                    blank_lz,
  output logic [3:0]              bcd_out,
  output logic                    n_en,
  output logic [NUM_DIGITS-1:0]   dig_sel_n,
  output logic                    frame_start
);

  localparam int IW   = clog2(NUM_DIGITS);
  localparam int MAXT = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int TW   = clog2(MAXT + 1);

  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_TICKS - 1);
  // With no gap, the reset-time GAP still needs one tick to leave.
  localparam logic [TW-1:0] GAP_LAST  = TW'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);
  localparam bit            HAS_GAP   = (GAP_TICKS != 0);

  logic                    tick;
  logic [4*NUM_DIGITS-1:0] shadow;
  scan_state_t             state;
  logic [IW-1:0]           idx;
  logic [TW-1:0]           tick_cnt;

  logic [IW-1:0]           next_idx;
  logic [3:0]              next_digit;
  logic                    upper_zero;
  logic                    next_blank;
  logic                    enter_show;
  logic                    enter_gap;

  scan_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Shadow register: takes a new digit set on the update strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (update) begin
      shadow <= digits_in;
    end
  end

  // Next slot selection, leading-zero test and transition decode.
  always_comb begin
    next_idx   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    next_digit = shadow[{next_idx, 2'b00} +: 4];
    upper_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(next_idx) && shadow[4*k +: 4] != 4'd0) begin
        upper_zero = 1'b0;
      end
    end
    // Digit 0 is never blanked so a zero value still shows "0".
    next_blank = blank_lz && (next_idx != '0) && upper_zero;
    enter_show = tick && (((state == S_GAP) && (tick_cnt == GAP_LAST)) ||
                          ((state == S_SHOW) && (tick_cnt == SHOW_LAST) && !HAS_GAP));
    enter_gap  = tick && (state == S_SHOW) && (tick_cnt == SHOW_LAST) && HAS_GAP;
  end

  // Scan FSM with registered display outputs, latched once per slot entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_GAP;
      idx         <= IDX_LAST;
      tick_cnt    <= '0;
      bcd_out     <= 4'd0;
      n_en        <= 1'b1;
      dig_sel_n   <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (enter_show) begin
        state       <= S_SHOW;
        idx         <= next_idx;
        tick_cnt    <= '0;
        bcd_out     <= next_digit;
        dig_sel_n   <= ~(NUM_DIGITS'(1) << next_idx);
        n_en        <= next_blank;
        frame_start <= (next_idx == '0);
      end else if (enter_gap) begin
        state     <= S_GAP;
        tick_cnt  <= '0;
        n_en      <= 1'b1;
        dig_sel_n <= '1;
      end else if (tick) begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Directed bench for digit_scan_mux with DIV=4, SHOW_TICKS=2, NUM_DIGITS=4.
// dut_a uses GAP_TICKS=1, dut_b uses GAP_TICKS=0; both share all inputs.
module tb_digit_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits_in;
  logic        update;
  logic        blank_lz;

  logic [3:0]  bcd_a, bcd_b;
  logic        nen_a, nen_b;
  logic [3:0]  sel_a, sel_b;
  logic        fs_a, fs_b;

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  digit_scan_mux #(
    .NUM_DIGITS (4),
    .DIV        (4),
    .SHOW_TICKS (2),
    .GAP_TICKS  (1)
  ) dut_a (
    .clk         (clk),
    .rst         (rst),
    .digits_in   (digits_in),
    .update      (update),
    .blank_lz    (blank_lz),
    .bcd_out     (bcd_a),
    .n_en        (nen_a),
    .dig_sel_n   (sel_a),
    .frame_start (fs_a)
  );

  digit_scan_mux #(
    .NUM_DIGITS (4),
    .DIV        (4),
    .SHOW_TICKS (2),
    .GAP_TICKS  (0)
  ) dut_b (
    .clk         (clk),
    .rst         (rst),
    .digits_in   (digits_in),
    .update      (update),
    .blank_lz    (blank_lz),
    .bcd_out     (bcd_b),
    .n_en        (nen_b),
    .dig_sel_n   (sel_b),
    .frame_start (fs_b)
  );

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_update(input logic [15:0] value);
    digits_in = value;
    update    = 1'b1;
    step(1);
    update    = 1'b0;
  endtask

  function automatic logic [3:0] cur_sel(input bit which);
    return which ? sel_b : sel_a;
  endfunction

  // Wait for a fresh entry into the slot whose select pattern is pat.
  task automatic wait_sel(input bit which, input logic [3:0] pat, input string tag);
    int guard;
    guard = 0;
    while (cur_sel(which) == pat && guard < 200) begin
      step(1);
      guard++;
    end
    while (cur_sel(which) != pat && guard < 200) begin
      step(1);
      guard++;
    end
    check({tag, "_wait"}, 32'(guard < 200), 32'd1);
  endtask

  // Number of consecutive sampled cycles with select equal to pat.
  task automatic run_len(input bit which, input logic [3:0] pat, output int len);
    len = 0;
    while (cur_sel(which) == pat && len < 100) begin
      step(1);
      len++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    digits_in = 16'h0000;
    update    = 1'b0;
    blank_lz  = 1'b0;

    // Reset state.
    step(2);
    check("rst_bcd", 32'(bcd_a), 32'h0);
    check("rst_nen", 32'(nen_a), 32'h1);
    check("rst_sel", 32'(sel_a), 32'hF);
    check("rst_fs",  32'(fs_a),  32'h0);

    // First SHOW is digit 0, four cycles after release (GAP of one tick).
    rst = 1'b0;
    step(3);
    check("start_dark", 32'(sel_a), 32'hF);
    step(1);
    check("start_sel", 32'(sel_a), 32'hE);
    check("start_fs",  32'(fs_a),  32'h1);
    check("start_bcd", 32'(bcd_a), 32'h0);
    check("start_nen", 32'(nen_a), 32'h0);
    step(1);
    check("fs_pulse_end", 32'(fs_a), 32'h0);

    // Scan order with 4321; update mid-slot leaves digit 0 showing 0.
    pulse_update(16'h4321);
    check("tear_hold0", 32'(bcd_a), 32'h0);
    wait_sel(1'b0, 4'hD, "d1");
    check("d1_bcd", 32'(bcd_a), 32'h2);
    check("d1_nen", 32'(nen_a), 32'h0);
    run_len(1'b0, 4'hD, n);
    check("lit_len", 32'(n), 32'd8);
    run_len(1'b0, 4'hF, n);
    check("gap_len", 32'(n), 32'd4);
    check("d2_sel", 32'(sel_a), 32'hB);
    check("d2_bcd", 32'(bcd_a), 32'h3);
    wait_sel(1'b0, 4'h7, "d3");
    check("d3_bcd", 32'(bcd_a), 32'h4);
    wait_sel(1'b0, 4'hE, "d0");
    check("d0_bcd", 32'(bcd_a), 32'h1);
    check("d0_fs",  32'(fs_a),  32'h1);
    n = 0;
    do begin
      step(1);
      n++;
    end while (fs_a == 1'b0 && n < 200);
    check("frame_len", 32'(n), 32'd48);

    // No-gap instance: back-to-back slots of 8 cycles, never all dark.
    wait_sel(1'b1, 4'hD, "ng_d1");
    check("ng_d1_bcd", 32'(bcd_b), 32'h2);
    run_len(1'b1, 4'hD, n);
    check("ng_lit_len", 32'(n), 32'd8);
    check("ng_next_sel", 32'(sel_b), 32'hB);
    check("ng_next_bcd", 32'(bcd_b), 32'h3);
    n = 0;
    repeat (96) begin
      if (sel_b == 4'hF) n++;
      step(1);
    end
    check("ng_no_dark", 32'(n), 32'd0);

    // Tear-free update in the middle of digit 1's slot.
    wait_sel(1'b0, 4'hD, "tf_d1");
    step(3);
    pulse_update(16'h9999);
    n = 0;
    for (int g = 0; g < 20 && sel_a == 4'hD; g++) begin
      if (bcd_a != 4'h2) n++;
      step(1);
    end
    check("tf_hold", 32'(n), 32'd0);
    wait_sel(1'b0, 4'hB, "tf_d2");
    check("tf_d2_bcd", 32'(bcd_a), 32'h9);

    // Leading-zero blanking with 0050.
    blank_lz = 1'b1;
    pulse_update(16'h0050);
    wait_sel(1'b0, 4'hE, "lz_d0");
    check("lz_d0_bcd", 32'(bcd_a), 32'h0);
    check("lz_d0_nen", 32'(nen_a), 32'h0);
    wait_sel(1'b0, 4'hD, "lz_d1");
    check("lz_d1_bcd", 32'(bcd_a), 32'h5);
    check("lz_d1_nen", 32'(nen_a), 32'h0);
    wait_sel(1'b0, 4'hB, "lz_d2");
    check("lz_d2_nen", 32'(nen_a), 32'h1);
    wait_sel(1'b0, 4'h7, "lz_d3");
    check("lz_d3_nen", 32'(nen_a), 32'h1);

    // All zeros: only digit 0 lit.
    pulse_update(16'h0000);
    wait_sel(1'b0, 4'hE, "z_d0");
    check("z_d0_nen", 32'(nen_a), 32'h0);
    check("z_d0_bcd", 32'(bcd_a), 32'h0);
    wait_sel(1'b0, 4'hD, "z_d1");
    check("z_d1_nen", 32'(nen_a), 32'h1);
    wait_sel(1'b0, 4'h7, "z_d3");
    check("z_d3_nen", 32'(nen_a), 32'h1);

    // Blanking disabled: every digit lit.
    blank_lz = 1'b0;
    wait_sel(1'b0, 4'hD, "nb_d1");
    check("nb_d1_nen", 32'(nen_a), 32'h0);
    wait_sel(1'b0, 4'h7, "nb_d3");
    check("nb_d3_nen", 32'(nen_a), 32'h0);

    // Non-BCD value passes through on digit 0 only.
    pulse_update(16'h123C);
    wait_sel(1'b0, 4'hE, "ib_d0");
    check("ib_d0_bcd", 32'(bcd_a), 32'hC);
    check("ib_d0_nen", 32'(nen_a), 32'h0);
    wait_sel(1'b0, 4'hD, "ib_d1");
    check("ib_d1_bcd", 32'(bcd_a), 32'h3);

    // Reset mid-SHOW of digit 2: dark at once, restart at digit 0.
    wait_sel(1'b0, 4'hB, "mr_d2");
    step(2);
    rst = 1'b1;
    #1;
    check("mr_nen", 32'(nen_a), 32'h1);
    check("mr_sel", 32'(sel_a), 32'hF);
    step(1);
    rst = 1'b0;
    step(3);
    check("mr_dark", 32'(sel_a), 32'hF);
    step(1);
    check("mr_sel0", 32'(sel_a), 32'hE);
    check("mr_fs",   32'(fs_a),  32'h1);
    check("mr_bcd",  32'(bcd_a), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
